// File: rtl/ram_stream_reader.sv
// Burst reader: issues sequential (wrapping) reads to a 1-cycle-latency RAM and
// streams the words through a 2-entry valid/ready buffer throttled by read credit.
package ram_stream_reader_pkg;
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction
endpackage

module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 8,
  localparam int ADDR_W = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_en,
  output logic                 ram_we,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [RAM_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0]   ONE_LEN   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  logic [1:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      left_q, left_d;
  logic                 in_flight_q, in_flight_d;
  logic                 in_flight_last_q, in_flight_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [RAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [RAM_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                 skid_last_q, skid_last_d;

  logic [ADDR_W:0] eff_len_s;
  logic            pop_s;
  logic [1:0]      used_s;
  logic            credit_s;
  logic            final_issue_s;

  // Credit: words buffered plus the read in flight, less the word leaving now.
  always_comb begin
    eff_len_s     = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    pop_s         = out_valid_q && out_ready;
    used_s        = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, in_flight_q};
    credit_s      = (used_s - {1'b0, pop_s}) < 2'd2;
    ram_en        = (state_q == READ) && credit_s;
    final_issue_s = ram_en && (left_q == ONE_LEN);
  end

  // Burst sequencing: latch the request, walk the wrapping address, finish on last handshake.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    left_d           = left_q;
    done_d           = 1'b0;
    in_flight_d      = ram_en;
    in_flight_last_d = final_issue_s;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_len_s != {(ADDR_W + 1){1'b0}}) begin
            state_d = READ;
            addr_d  = base_addr;
            left_d  = eff_len_s;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (ram_en) begin
          addr_d  = (addr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : addr_q + ONE_ADDR;
          left_d  = left_q - ONE_LEN;
          state_d = final_issue_s ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (pop_s && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Two-slot buffer: the output slot refills from the skid slot first, then from the RAM.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || pop_s) begin
      if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        if (in_flight_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = ram_dout;
          skid_last_d  = in_flight_last_q;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_flight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_dout;
        out_last_d  = in_flight_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (in_flight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_dout;
      skid_last_d  = in_flight_last_q;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      addr_q           <= {ADDR_W{1'b0}};
      left_q           <= {(ADDR_W + 1){1'b0}};
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= {RAM_WIDTH{1'b0}};
      out_last_q       <= 1'b0;
      skid_valid_q     <= 1'b0;
      skid_data_q      <= {RAM_WIDTH{1'b0}};
      skid_last_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      addr_q           <= addr_d;
      left_q           <= left_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_last_q       <= out_last_d;
      skid_valid_q     <= skid_valid_d;
      skid_data_q      <= skid_data_d;
      skid_last_q      <= skid_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_we    = 1'b0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: a RAM model feeds the DUT and a
// burst-level reference model predicts every streamed word, done and busy.
module tb_ram_stream_reader;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          nrst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic [W-1:0]  ram_dout;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  exp_q [$];
  bit            m_busy       = 1'b0;
  bit            m_done       = 1'b0;
  bit            lat_on       = 1'b0;
  bit            stall_prev   = 1'b0;
  bit            full_ready   = 1'b1;
  int            issued       = 0;
  int            popped       = 0;
  int            m_eff        = 0;
  int            lat_cnt      = 0;
  int            cyc          = 0;
  int            last_pop_cyc = 0;
  int            duty         = 100;
  logic [AW-1:0] m_base       = '0;
  logic [W-1:0]  prev_data    = '0;
  logic          prev_last    = 1'b0;

  ram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM, one cycle of latency.
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_out_data", out_data, 0);
  endtask

  // Reference model: whole bursts are predicted at acceptance and consumed per handshake.
  initial begin : model
    bit busy_now;
    bit nxt_done;
    int eff;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        exp_q.delete();
        m_busy     = 1'b0;
        m_done     = 1'b0;
        lat_on     = 1'b0;
        stall_prev = 1'b0;
        issued     = 0;
        popped     = 0;
        m_eff      = 0;
      end else begin
        busy_now = m_busy;
        nxt_done = 1'b0;
        check_eq("busy", busy, m_busy);
        check_eq("done", done, m_done);
        check_eq("ram_we", ram_we, 0);
        check_eq("valid_without_word", out_valid && (exp_q.size() == 0), 0);
        if (!m_busy) check_eq("ram_en_idle", ram_en, 0);
        if (ram_en) begin
          check_eq("ram_addr", ram_addr, (m_base + issued) % D);
          check_eq("read_overrun", issued < m_eff, 1);
          issued++;
        end
        if (lat_on) begin
          lat_cnt++;
          if (lat_cnt == 2) check_eq("first_word_early", out_valid, 0);
          if (lat_cnt == 3) begin
            check_eq("first_word_latency", out_valid, 1);
            lat_on = 1'b0;
          end
        end
        if (stall_prev) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_data", out_data, prev_data);
          check_eq("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          check_eq("data", out_data, exp_q[0]);
          check_eq("last", out_last, exp_q.size() == 1);
          if (full_ready && popped > 0) check_eq("word_gap", cyc - last_pop_cyc, 1);
          last_pop_cyc = cyc;
          void'(exp_q.pop_front());
          popped++;
          if (exp_q.size() == 0) begin
            nxt_done = 1'b1;
            m_busy   = 1'b0;
          end
        end
        check_eq("outstanding_le_2", (issued - popped) <= 2, 1);
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (start && !busy_now) begin
          eff = (int'(len) > D) ? D : int'(len);
          if (eff == 0) begin
            nxt_done = 1'b1;
          end else begin
            m_busy  = 1'b1;
            m_base  = base_addr;
            m_eff   = eff;
            issued  = 0;
            popped  = 0;
            lat_on  = 1'b1;
            lat_cnt = 0;
            for (int k = 0; k < eff; k++) exp_q.push_back(mem[(int'(base_addr) + k) % D]);
          end
        end
        m_done = nxt_done;
      end
    end
  end

  // Sink ready pattern at the requested duty cycle.
  initial begin : sink
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(99) < duty);
    end
  end

  task automatic set_duty(input int d);
    duty       = d;
    full_ready = (d >= 100);
    @(posedge clk);
  endtask

  task automatic run_burst(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW + 1)'(l);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = (AW + 1)'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((m_busy || m_done || exp_q.size() != 0) && n < 300);
    check_eq("idle_timeout", n < 300, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    nrst      = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < D; i++) mem[i] = W'(i + 16);
    #2 nrst = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    run_burst(2, 4); wait_idle();
    run_burst(6, 5); wait_idle();
    run_burst(3, 0); wait_idle();
    run_burst(1, 9); wait_idle();

    set_duty(30);
    run_burst(0, 8); wait_idle();
    set_duty(100);

    // start during a burst is ignored, start in the done cycle is taken
    run_burst(4, 6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = 3'd0; len = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!m_done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("done_wait_timeout", n < 300, 1);
    start = 1'b1; base_addr = 3'd5; len = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("coincident_start_busy", busy, 1);
    wait_idle();

    // asynchronous reset with a read in flight
    run_burst(3, 6);
    @(posedge clk);
    #1 nrst = 1'b0;
    #2 check_reset_outputs();
    #3 nrst = 1'b1;
    run_burst(0, 2); wait_idle();

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < D; i++) mem[i] = W'($urandom);
      case ($urandom_range(2))
        0:       set_duty(100);
        1:       set_duty(30);
        default: set_duty(65);
      endcase
      run_burst($urandom_range(D - 1), $urandom_range(9));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
